fetch_stage: RTL and testbench

- Instruction fetch stage plus IF/ID pipeline register, directly upstream of the decode/control stage.
- Holds the PC, issues requests to instruction memory over a hold-until-valid handshake, and presents {instruction, pc, valid} to decode.
- Applies branch/jump redirects from execute, stalls from the hazard logic, and halt/step/resume from the external debugger.
- Injects NOP 0x00000013 on flush and halt, so decode sees a clean NOP bubble.

---
 rtl/fetch_pkg.sv | 17 +
 rtl/fetch_stage_if_id_reg.sv | 52 +++++
 rtl/fetch_stage.sv | 126 ++++++++++++
 tb/tb_fetch_stage.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fetch_pkg;

  localparam int FETCH_XLEN = 32;
  localparam logic [31:0] FETCH_RESET_PC = 32'h0000_0000;
  // addi x0,x0,0 -- decode sees this as a harmless bubble
  localparam logic [31:0] FETCH_NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    HALTED = 2'd1,
    STEP   = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: flush > load > bubble > hold, resets to the NOP bubble.
// Latency: 1 cycle from i_load to o_* outputs.
// Backpressure: holds contents whenever no control input is active (stall).
// Ports: clk/rst_n (async active-low); i_flush, i_load, i_bubble controls;
//   i_instr/i_pc incoming fetch; o_instr/o_pc/o_valid towards decode.
import fetch_pkg::*;

module if_id_reg #(
  parameter int              XLEN      = FETCH_XLEN,
  parameter logic [XLEN-1:0] NOP_INSTR = XLEN'(FETCH_NOP_INSTR)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_flush,
  input  logic            i_load,
  input  logic            i_bubble,
  input  logic [XLEN-1:0] i_instr,
  input  logic [XLEN-1:0] i_pc,
  output logic [XLEN-1:0] o_instr,
  output logic [XLEN-1:0] o_pc,
  output logic            o_valid
);

  logic [XLEN-1:0] r_instr;
  logic [XLEN-1:0] r_pc;
  logic            r_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_instr <= NOP_INSTR;
      r_pc    <= '0;
      r_valid <= 1'b0;
    end else if (i_flush) begin
      r_instr <= NOP_INSTR;
      r_pc    <= '0;
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_instr <= i_instr;
      r_pc    <= i_pc;
      r_valid <= 1'b1;
    end else if (i_bubble) begin
      // pc is left as-is; only the valid bit and the NOP word matter to decode
      r_instr <= NOP_INSTR;
      r_valid <= 1'b0;
    end
  end

  assign o_instr = r_instr;
  assign o_pc    = r_pc;
  assign o_valid = r_valid;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, imem request handshake, debug run/halt/step, IF/ID register.
// Latency: IF/ID updates 1 cycle after address issue; 1 instr/cycle with zero-wait memory.
// Backpressure: stall holds PC and IF/ID; memory wait inserts NOP bubbles; redirect overrides all.
// Ports: clk, rst_n; imem_addr/imem_req out, imem_rdata/imem_valid in; stall; br_taken/br_target;
//   dbg_halt_req/dbg_resume_req/dbg_step_req pulses, dbg_pc_wr/dbg_pc_wdata, dbg_halted out;
//   if_id_instr/if_id_pc/if_id_valid to decode.
// Build option: define FETCH_DBG_PC_WR_EN to let the debugger write the PC while halted.
import fetch_pkg::*;

module fetch_stage #(
  parameter int              XLEN      = FETCH_XLEN,
  parameter logic [XLEN-1:0] RESET_PC  = XLEN'(FETCH_RESET_PC),
  parameter logic [XLEN-1:0] NOP_INSTR = XLEN'(FETCH_NOP_INSTR)
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic [XLEN-1:0] imem_addr,
  output logic            imem_req,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            imem_valid,
  input  logic            stall,
  input  logic            br_taken,
  input  logic [XLEN-1:0] br_target,
  input  logic            dbg_halt_req,
  input  logic            dbg_resume_req,
  input  logic            dbg_step_req,
  input  logic            dbg_pc_wr,
  input  logic [XLEN-1:0] dbg_pc_wdata,
  output logic            dbg_halted,
  output logic [XLEN-1:0] if_id_instr,
  output logic [XLEN-1:0] if_id_pc,
  output logic            if_id_valid
);

  fetch_state_t    r_state;
  fetch_state_t    w_state_nxt;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] w_pc_nxt;
  logic            r_halted;
  logic            w_req_st;
  logic            w_accept;

`ifndef FETCH_DBG_PC_WR_EN
  // Debug PC write is not built; ports stay so instantiations are unchanged.
  logic w_unused_dbg_pc;
  assign w_unused_dbg_pc = dbg_pc_wr ^ (^dbg_pc_wdata);
`endif

  // Request is gated by rst_n directly so it is low throughout reset and
  // rises in the very first cycle after release.
  assign imem_req  = rst_n & w_req_st;
  assign imem_addr = r_pc;
  assign w_accept  = imem_req & imem_valid & ~stall & ~br_taken;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= RUN;
      r_pc     <= RESET_PC;
      r_halted <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_pc     <= w_pc_nxt;
      r_halted <= (w_state_nxt == HALTED);
    end
  end

  // Next state and request; redirects never change state.
  always_comb begin
    w_state_nxt = r_state;
    w_req_st    = 1'b1;
    case (r_state)
      RUN: begin
        // any same-cycle accept still completes; otherwise the access is dropped
        if (dbg_halt_req) w_state_nxt = HALTED;
      end
      HALTED: begin
        w_req_st = 1'b0;
        if (dbg_resume_req)    w_state_nxt = RUN;
        else if (dbg_step_req) w_state_nxt = STEP;
      end
      STEP: begin
        if (w_accept) w_state_nxt = HALTED;
      end
      default: begin
        w_state_nxt = RUN;
      end
    endcase
  end

  // PC: redirect beats everything (including stall and debugger write).
  always_comb begin
    w_pc_nxt = r_pc;
    if (br_taken) begin
      w_pc_nxt = br_target;
    end
`ifdef FETCH_DBG_PC_WR_EN
    else if (dbg_pc_wr && (r_state == HALTED)) begin
      w_pc_nxt = dbg_pc_wdata;
    end
`endif
    else if (w_accept) begin
      w_pc_nxt = r_pc + XLEN'(4);
    end
  end

  assign dbg_halted = r_halted;

  // Without an accept and without a stall, decode gets a NOP bubble
  // (memory wait, halted, or leaving RUN mid-access).
  if_id_reg #(
    .XLEN      (XLEN),
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_flush  (br_taken),
    .i_load   (w_accept),
    .i_bubble (~stall),
    .i_instr  (imem_rdata),
    .i_pc     (r_pc),
    .o_instr  (if_id_instr),
    .o_pc     (if_id_pc),
    .o_valid  (if_id_valid)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: directed stimulus with a wait-state memory model.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef FETCH_DBG_PC_WR_EN
  localparam logic [31:0] EXP_PC = 32'h0000_0100;
`else
  localparam logic [31:0] EXP_PC = 32'h0000_0014;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] imem_addr;
  logic        imem_req;
  logic [31:0] imem_rdata;
  logic        imem_valid;
  logic        stall;
  logic        br_taken;
  logic [31:0] br_target;
  logic        dbg_halt_req;
  logic        dbg_resume_req;
  logic        dbg_step_req;
  logic        dbg_pc_wr;
  logic [31:0] dbg_pc_wdata;
  logic        dbg_halted;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc;
  logic        if_id_valid;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_addr      (imem_addr),
    .imem_req       (imem_req),
    .imem_rdata     (imem_rdata),
    .imem_valid     (imem_valid),
    .stall          (stall),
    .br_taken       (br_taken),
    .br_target      (br_target),
    .dbg_halt_req   (dbg_halt_req),
    .dbg_resume_req (dbg_resume_req),
    .dbg_step_req   (dbg_step_req),
    .dbg_pc_wr      (dbg_pc_wr),
    .dbg_pc_wdata   (dbg_pc_wdata),
    .dbg_halted     (dbg_halted),
    .if_id_instr    (if_id_instr),
    .if_id_pc       (if_id_pc),
    .if_id_valid    (if_id_valid)
  );

  // ---------------- memory model: word derived from address, n_wait wait states
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[31:16] ^ 16'hC0DE, a[15:0]};
  endfunction

  int          n_wait;
  int          age_r;
  int          cur_age;
  logic        last_req;
  logic [31:0] last_addr;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_req  <= 1'b0;
      last_addr <= '0;
      age_r     <= 0;
    end else begin
      last_req  <= imem_req;
      last_addr <= imem_addr;
      age_r     <= imem_req ? cur_age + 1 : 0;
    end
  end

  always_comb begin
    cur_age    = (last_req && (imem_addr == last_addr)) ? age_r : 0;
    imem_valid = imem_req && (cur_age >= n_wait);
    imem_rdata = mem_word(imem_addr);
  end

  // ---------------- scoreboard queues
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } obs_t;

  typedef struct {
    string       nm;
    logic [31:0] act;
    logic [31:0] exp;
  } chk_t;

  obs_t sb_q[$];
  chk_t chk_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  logic done  = 1'b0;
  logic stall_q = 1'b0;

  task automatic push_fetch(input logic [31:0] a);
    obs_t e;
    e.instr = mem_word(a);
    e.pc    = a;
    sb_q.push_back(e);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    chk_t c;
    c.nm  = nm;
    c.act = act;
    c.exp = exp;
    chk_q.push_back(c);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- monitor: all comparisons happen here
  always @(posedge clk) stall_q <= stall;

  always @(negedge clk) begin
    obs_t e;
    chk_t c;
    while (chk_q.size() > 0) begin
      c = chk_q.pop_front();
      n_vec++;
      if (c.act !== c.exp) begin
        n_err++;
        $display("FAIL %s: got %h want %h", c.nm, c.act, c.exp);
      end
    end
    // a fresh IF/ID entry appears only if the previous edge was not stalled
    if (rst_n && if_id_valid && !stall_q) begin
      n_vec++;
      if (sb_q.size() == 0) begin
        n_err++;
        $display("FAIL ifid_unexpected: got pc %h instr %h want no fetch", if_id_pc, if_id_instr);
      end else begin
        e = sb_q.pop_front();
        if ({if_id_instr, if_id_pc} !== {e.instr, e.pc}) begin
          n_err++;
          $display("FAIL ifid: got pc %h instr %h want pc %h instr %h",
                   if_id_pc, if_id_instr, e.pc, e.instr);
        end
      end
    end
    if (done) begin
      n_vec++;
      if (sb_q.size() != 0) begin
        n_err++;
        $display("FAIL ifid_missing: got %0d outstanding want 0", sb_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "timeout");
  end

  // ---------------- stimulus
  initial begin
    rst_n = 1'b0; stall = 1'b0; br_taken = 1'b0; br_target = '0;
    dbg_halt_req = 1'b0; dbg_resume_req = 1'b0; dbg_step_req = 1'b0;
    dbg_pc_wr = 1'b0; dbg_pc_wdata = '0; n_wait = 0;
    repeat (2) tick();
    chk("rst_req",    imem_req,    0);
    chk("rst_addr",   imem_addr,   0);
    chk("rst_valid",  if_id_valid, 0);
    chk("rst_instr",  if_id_instr, NOP);
    chk("rst_pc",     if_id_pc,    0);
    chk("rst_halted", dbg_halted,  0);

    // zero-wait streaming 0x0, 0x4, 0x8
    rst_n = 1'b1;
    #1;
    chk("req_after_rst", imem_req, 1);
    chk("addr0", imem_addr, 32'h0); push_fetch(32'h0); tick();
    chk("addr4", imem_addr, 32'h4); push_fetch(32'h4); tick();
    chk("addr8", imem_addr, 32'h8); stall = 1'b1;       tick();

    // 3-cycle stall at 0x8
    chk("stall_addr",  imem_addr,   32'h8);
    chk("stall_pc",    if_id_pc,    32'h4);
    chk("stall_instr", if_id_instr, mem_word(32'h4));
    chk("stall_req",   imem_req,    1);
    tick();
    tick();
    chk("stall_addr3", imem_addr, 32'h8);
    stall = 1'b0; push_fetch(32'h8); tick();

    // redirect wins over stall
    chk("addrC", imem_addr, 32'hC);
    stall = 1'b1; br_taken = 1'b1; br_target = 32'h40; tick();
    stall = 1'b0; br_taken = 1'b0;
    chk("br_addr",  imem_addr,   32'h40);
    chk("br_instr", if_id_instr, NOP);
    chk("br_valid", if_id_valid, 0);
    chk("br_pc",    if_id_pc,    0);

    // two wait states at 0x40
    n_wait = 2; push_fetch(32'h40); tick();
    chk("wait1_addr",  imem_addr,   32'h40);
    chk("wait1_valid", if_id_valid, 0);
    chk("wait1_instr", if_id_instr, NOP);
    tick();
    chk("wait2_addr",  imem_addr,   32'h40);
    chk("wait2_valid", if_id_valid, 0);
    tick();
    chk("wait_next", imem_addr, 32'h44);

    // redirect to 0x10 and halt there before any accept
    br_taken = 1'b1; br_target = 32'h10; tick();
    br_taken = 1'b0;
    chk("addr10", imem_addr, 32'h10);
    dbg_halt_req = 1'b1; tick();
    dbg_halt_req = 1'b0; n_wait = 0;
    chk("halt_halted", dbg_halted,  1);
    chk("halt_req",    imem_req,    0);
    chk("halt_addr",   imem_addr,   32'h10);
    chk("halt_valid",  if_id_valid, 0);
    tick();
    chk("halt2_halted", dbg_halted, 1);
    chk("halt2_req",    imem_req,   0);

    // single step fetches exactly 0x10
    dbg_step_req = 1'b1; tick();
    dbg_step_req = 1'b0;
    chk("step_req",    imem_req,   1);
    chk("step_halted", dbg_halted, 0);
    chk("step_addr",   imem_addr,  32'h10);
    push_fetch(32'h10); tick();
    chk("stepd_halted", dbg_halted, 1);
    chk("stepd_req",    imem_req,   0);
    chk("stepd_addr",   imem_addr,  32'h14);
    tick();
    chk("stepd_valid", if_id_valid, 0);

    // debugger PC write (effective only when the option is built), then resume
    dbg_pc_wr = 1'b1; dbg_pc_wdata = 32'h100; tick();
    dbg_pc_wr = 1'b0;
    chk("pcwr_addr", imem_addr, EXP_PC);
    dbg_resume_req = 1'b1; tick();
    dbg_resume_req = 1'b0;
    chk("resume_halted", dbg_halted, 0);
    chk("resume_req",    imem_req,   1);
    chk("resume_addr",   imem_addr,  EXP_PC);
    push_fetch(EXP_PC); tick();

    // halt with same-cycle accept: the accept completes
    chk("run_addr", imem_addr, EXP_PC + 32'h4);
    push_fetch(EXP_PC + 32'h4); dbg_halt_req = 1'b1; tick();
    dbg_halt_req = 1'b0;
    chk("haltacc_halted", dbg_halted, 1);
    chk("haltacc_addr",   imem_addr,  EXP_PC + 32'h8);
    chk("haltacc_req",    imem_req,   0);
    tick();
    chk("haltacc_valid", if_id_valid, 0);

    // redirect while halted stays halted; PC wraps at the top of the space
    br_taken = 1'b1; br_target = 32'hFFFF_FFFC; tick();
    br_taken = 1'b0;
    chk("hbr_halted", dbg_halted, 1);
    chk("hbr_addr",   imem_addr,  32'hFFFF_FFFC);
    dbg_resume_req = 1'b1; tick();
    dbg_resume_req = 1'b0;
    chk("wrap_req", imem_req, 1);
    push_fetch(32'hFFFF_FFFC); tick();
    chk("wrap_addr", imem_addr, 32'h0);
    push_fetch(32'h0); dbg_halt_req = 1'b1; tick();
    dbg_halt_req = 1'b0;
    chk("end_halted", dbg_halted, 1);
    chk("end_addr",   imem_addr,  32'h4);
    repeat (3) tick();
    done = 1'b1;
  end

endmodule
